// File: rtl/amiga_kbd_pkg.sv
// Shared types and keycodes for the Amiga keyboard-side serial transmitter.
package amiga_kbd_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HS, RESYNC} state_e;
  typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_e;

  localparam logic [7:0] KBD_LOST_SYNC    = 8'hF9;
  localparam logic [7:0] KBD_INIT_POWERUP = 8'hFD;
  localparam logic [7:0] KBD_TERM_POWERUP = 8'hFE;

  // Amiga wire order: bits 6..0 first, key-up flag (bit 7) last.
  function automatic logic [7:0] wire_order(input logic [7:0] code);
    return {code[6:0], code[7]};
  endfunction

endpackage

// File: rtl/amiga_kbd_hs_filter.sv
// KDAT_IN synchroniser plus consecutive-low run counter; emits a one-cycle
// hs_seen_o pulse when the run reaches HS_MIN_CYCLES. clear_i restarts the run.
module amiga_kbd_hs_filter #(
  parameter int HS_MIN_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic kdat_i,
  input  logic clear_i,
  output logic hs_seen_o
);

  localparam int CW = $clog2(HS_MIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HS_MIN_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(HS_MIN_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q;
  logic          hs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      cnt_q <= '0;
      hs_q  <= 1'b0;
    end else begin
      s1_q <= kdat_i;
      s2_q <= s1_q;
      if (clear_i || s2_q)
        cnt_q <= '0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CW'(1);
      // Saturating at CNT_MAX keeps a long low from re-firing.
      hs_q <= !clear_i && !s2_q && (cnt_q == CNT_LAST);
    end
  end

  assign hs_seen_o = hs_q;

endmodule

// File: rtl/amiga_kbd_tx.sv
// Amiga keyboard-side serial transmitter (KCLK/KDAT open-drain drive).
// Define AMIGA_KBD_TX_POWERUP_EN to run resync + 0xFD/0xFE after reset.
module amiga_kbd_tx
  import amiga_kbd_pkg::*;
#(
  parameter int BIT_CYCLES     = 20,
  parameter int HS_MIN_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 143000
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [7:0] KEY_CODE,
  input  logic       KEY_VALID,
  output logic       KEY_READY,
  input  logic       KDAT_IN,
  output logic       KDAT_LOW,
  output logic       KCLK_LOW
);

  localparam int BW = $clog2(BIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BIT_RELOAD = BW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);

`ifdef AMIGA_KBD_TX_POWERUP_EN
  localparam state_e RST_STATE = RESYNC;
  localparam logic   PU_RST    = 1'b1;
`else
  localparam state_e RST_STATE = IDLE;
  localparam logic   PU_RST    = 1'b0;
`endif

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [BW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    code_q, code_d;
  logic [TW-1:0] to_q, to_d;
  logic          run_q;
  logic          key_pend_q, key_pend_d;
  logic          cur_key_q, cur_key_d;
  logic          resync_q, resync_d;
  logic          pu_init_q, pu_init_d;
  logic          pu_term_q, pu_term_d;

  logic          hs_seen, hs_clear, key_pend_nxt, start;
  logic [7:0]    start_sr;
  state_e        start_state;

  assign hs_clear = (state_q != WAIT_HS);

  amiga_kbd_hs_filter #(.HS_MIN_CYCLES(HS_MIN_CYCLES)) u_hs (
    .clk_i     (CLK),
    .rst_ni    (nRESET),
    .kdat_i    (KDAT_IN),
    .clear_i   (hs_clear),
    .hs_seen_o (hs_seen)
  );

  // Outputs are combinational from state so reset releases the lines at once.
  assign KEY_READY = run_q && (state_q == IDLE);
  assign KDAT_LOW  = run_q && (state_q == SEND || state_q == RESYNC) && sr_q[7];
  assign KCLK_LOW  = run_q && (state_q == SEND || state_q == RESYNC) && (phase_q == PH_B);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= RST_STATE;
      phase_q    <= PH_A;
      tmr_q      <= BIT_RELOAD;
      bit_q      <= '0;
      sr_q       <= 8'h80;
      code_q     <= '0;
      to_q       <= '0;
      run_q      <= 1'b0;
      key_pend_q <= 1'b0;
      cur_key_q  <= 1'b0;
      resync_q   <= 1'b0;
      pu_init_q  <= PU_RST;
      pu_term_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      code_q     <= code_d;
      to_q       <= to_d;
      run_q      <= 1'b1;
      key_pend_q <= key_pend_d;
      cur_key_q  <= cur_key_d;
      resync_q   <= resync_d;
      pu_init_q  <= pu_init_d;
      pu_term_q  <= pu_term_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tmr_d        = tmr_q;
    bit_d        = bit_q;
    sr_d         = sr_q;
    code_d       = code_q;
    to_d         = to_q;
    key_pend_d   = key_pend_q;
    cur_key_d    = cur_key_q;
    resync_d     = resync_q;
    pu_init_d    = pu_init_q;
    pu_term_d    = pu_term_q;
    key_pend_nxt = key_pend_q;
    start        = 1'b0;
    start_sr     = sr_q;
    start_state  = SEND;

    if (run_q) begin
      case (state_q)
        IDLE: begin
          if (KEY_VALID) begin
            code_d     = KEY_CODE;
            key_pend_d = 1'b1;
            cur_key_d  = 1'b1;
            start      = 1'b1;
            start_sr   = wire_order(KEY_CODE);
          end
        end
        SEND, RESYNC: begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - BW'(1);
          end else begin
            tmr_d = BIT_RELOAD;
            case (phase_q)
              PH_A: phase_d = PH_B;
              PH_B: phase_d = PH_C;
              default: begin
                phase_d = PH_A;
                if (state_q == RESYNC || bit_q == 3'd7) begin
                  state_d = WAIT_HS;
                  to_d    = '0;
                  if (state_q == RESYNC) resync_d = 1'b1;
                end else begin
                  bit_d = bit_q + 3'd1;
                  sr_d  = {sr_q[6:0], 1'b0};
                end
              end
            endcase
          end
        end
        WAIT_HS: begin
          if (hs_seen) begin
            cur_key_d = 1'b0;
            start     = 1'b1;
            if (resync_q) begin
              resync_d = 1'b0;
              if (pu_init_q) begin
                pu_init_d = 1'b0;
                pu_term_d = 1'b1;
                start_sr  = wire_order(KBD_INIT_POWERUP);
              end else begin
                start_sr  = wire_order(KBD_LOST_SYNC);
              end
            end else begin
              // The latched key stays pending until its own byte is acknowledged.
              key_pend_nxt = key_pend_q && !cur_key_q;
              key_pend_d   = key_pend_nxt;
              if (key_pend_nxt) begin
                cur_key_d = 1'b1;
                start_sr  = wire_order(code_q);
              end else if (pu_term_q) begin
                pu_term_d = 1'b0;
                start_sr  = wire_order(KBD_TERM_POWERUP);
              end else begin
                start   = 1'b0;
                state_d = IDLE;
              end
            end
          end else begin
            if (to_q != TO_MAX) to_d = to_q + TW'(1);
            if (to_q == TO_LAST) begin
              start       = 1'b1;
              start_state = RESYNC;
              start_sr    = 8'h80;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      state_d = start_state;
      sr_d    = start_sr;
      tmr_d   = BIT_RELOAD;
      phase_d = PH_A;
      bit_d   = '0;
    end
  end

endmodule
